mult_div_unit: RTL

//  Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair.

---
 rtl/mult_div_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: fixed-latency pipelined multiply
// (with MADD/MSUB accumulate) and restoring divide producing one quotient bit per cycle.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [3:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iFlush,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO
);
  localparam int CW = $clog2(WIDTH + MUL_LATENCY + 2);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t stateReg, stateNext;
  logic busy, mulFinish, divFinish, accept;
  logic isMulOp, isDivOp, isSignedOp, isKnownOp;

  logic [CW-1:0]      cntReg;
  logic [3:0]         opReg;
  logic [WIDTH:0]     mulAReg, mulBReg;
  logic [WIDTH-1:0]   divRemReg, divQuoReg, divisorReg;
  logic               quoNegReg, remNegReg, divZeroPendReg;
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               doneReg, divZeroReg;

  logic [WIDTH-1:0]   aMag, bMag;
  logic [2*WIDTH-1:0] mulProd, mulResult, mulAcc;
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [WIDTH-1:0]   divRemNext, quoFix, remFix;

  always_comb begin
    isMulOp    = (iOp == OP_MULT) || (iOp == OP_MULTU) || (iOp == OP_MADD) ||
                 (iOp == OP_MADDU) || (iOp == OP_MSUB) || (iOp == OP_MSUBU);
    isDivOp    = (iOp == OP_DIV) || (iOp == OP_DIVU);
    isSignedOp = ~iOp[0];
    isKnownOp  = (iOp <= OP_MTLO);
    accept     = iStart && !busy && !iFlush;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) stateReg <= IDLE;
    else      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (accept && isMulOp)      stateNext = MUL;
        else if (accept && isDivOp) stateNext = DIV;
      end
      MUL:     if (mulFinish || iFlush) stateNext = IDLE;
      DIV:     if (divFinish || iFlush) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy      = (stateReg != IDLE);
    mulFinish = (stateReg == MUL) && (cntReg == MUL_LAST);
    divFinish = (stateReg == DIV) && (cntReg == DIV_LAST);
  end

  // Operands are held stable while busy, so the delay line needs no valid bits.
  always_comb begin
    mulProd = {{(WIDTH-1){mulAReg[WIDTH]}}, mulAReg} * {{(WIDTH-1){mulBReg[WIDTH]}}, mulBReg};
  end

  generate
    if (MUL_LATENCY == 1) begin : gNoPipe
      assign mulResult = mulProd;
    end else begin : gPipe
      logic [MUL_LATENCY-2:0][2*WIDTH-1:0] prodPipe;
      always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
          prodPipe <= '0;
        end else begin
          prodPipe[0] <= mulProd;
          for (int i = 1; i < MUL_LATENCY - 1; i++) prodPipe[i] <= prodPipe[i-1];
        end
      end
      assign mulResult = prodPipe[MUL_LATENCY-2];
    end
  endgenerate

  always_comb begin
    case (opReg)
      OP_MADD, OP_MADDU: mulAcc = {hiReg, loReg} + mulResult;
      OP_MSUB, OP_MSUBU: mulAcc = {hiReg, loReg} - mulResult;
      default:           mulAcc = mulResult;
    endcase
  end

  always_comb begin
    aMag       = (isSignedOp && iA[WIDTH-1]) ? -iA : iA;
    bMag       = (isSignedOp && iB[WIDTH-1]) ? -iB : iB;
    divShift   = {divRemReg, divQuoReg[WIDTH-1]};
    divGe      = (divShift >= {1'b0, divisorReg});
    // Remainder stays below the divisor, so the difference always fits WIDTH bits.
    divRemNext = divGe ? (divShift[WIDTH-1:0] - divisorReg) : divShift[WIDTH-1:0];
    quoFix     = quoNegReg ? -divQuoReg : divQuoReg;
    remFix     = remNegReg ? -divRemReg : divRemReg;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cntReg         <= '0;
      opReg          <= '0;
      mulAReg        <= '0;
      mulBReg        <= '0;
      divRemReg      <= '0;
      divQuoReg      <= '0;
      divisorReg     <= '0;
      quoNegReg      <= 1'b0;
      remNegReg      <= 1'b0;
      divZeroPendReg <= 1'b0;
      hiReg          <= '0;
      loReg          <= '0;
      doneReg        <= 1'b0;
      divZeroReg     <= 1'b0;
    end else begin
      doneReg <= mulFinish || divFinish;
      if (busy) cntReg <= cntReg + 1'b1;
      if (accept) begin
        cntReg         <= '0;
        opReg          <= iOp;
        mulAReg        <= {isSignedOp & iA[WIDTH-1], iA};
        mulBReg        <= {isSignedOp & iB[WIDTH-1], iB};
        divRemReg      <= '0;
        divQuoReg      <= aMag;
        divisorReg     <= bMag;
        quoNegReg      <= isSignedOp & (iA[WIDTH-1] ^ iB[WIDTH-1]);
        remNegReg      <= isSignedOp & iA[WIDTH-1];
        divZeroPendReg <= (iB == '0);
        if (isKnownOp)       divZeroReg <= 1'b0;
        if (iOp == OP_MTHI)  hiReg <= iA;
        if (iOp == OP_MTLO)  loReg <= iA;
      end
      if ((stateReg == DIV) && !divFinish) begin
        divRemReg <= divRemNext;
        divQuoReg <= {divQuoReg[WIDTH-2:0], divGe};
      end
      if (mulFinish) {hiReg, loReg} <= mulAcc;
      if (divFinish) begin
        hiReg      <= remFix;
        loReg      <= divZeroPendReg ? '1 : quoFix;
        divZeroReg <= divZeroPendReg;
      end
    end
  end

  assign oBusy    = busy;
  assign oDone    = doneReg;
  assign oDivZero = divZeroReg;
  assign oHI      = hiReg;
  assign oLO      = loReg;
endmodule
